shift_serdes_var: RTL and testbench

Parametrised full-duplex shift engine. A parallel word is loaded through a ready/valid handshake, shifted out serially one bit per Shift_En tick while serial input is shifted in, and the received word is delivered on a ready/valid output slot with backpressure. It supports LSB-first or MSB-first order and a per-word rotate mode. It is the next generation of the team's fixed-width shift registers and sits between bit-rate enable generators (e.g. SPI/UART tick dividers) and word-level datapaths.

---
 rtl/shift_serdes_var.sv | 115 +++++++++++
 tb/tb_shift_serdes_var.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_serdes_var.sv
// Full-duplex parallel/serial shift engine with ready/valid word load and a
// backpressured received-word output slot.
module shift_serdes_var #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_Valid,
    output logic             Load_Ready,
    input  logic [WIDTH-1:0] D,
    input  logic             Rotate,
    input  logic             Shift_En,
    input  logic             Shift_In,
    input  logic             Abort,
    output logic             Shift_Out,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Busy,
    output logic             Done,
    output logic             Word_Valid,
    output logic [WIDTH-1:0] Word_Data,
    input  logic             Word_Ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             rot;
    logic             inbit;
    logic             slot_free;
    logic [WIDTH-1:0] shifted;

    assign Shift_Out  = (MSB_FIRST != 0) ? Data_Out[WIDTH-1] : Data_Out[0];
    assign inbit      = rot ? Shift_Out : Shift_In;
    assign Load_Ready = (state == IDLE);
    assign Busy       = (state != IDLE);
    assign slot_free  = !Word_Valid || Word_Ready;

    // A one-bit register has no neighbours to shift from, so it just takes inbit.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = inbit;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {Data_Out[WIDTH-2:0], inbit};
        end else begin : g_lsb
            assign shifted = {inbit, Data_Out[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rot        <= 1'b0;
            Data_Out   <= '0;
            Word_Data  <= '0;
            Word_Valid <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            // Consumer handshake; a transfer on the same edge overrides below.
            if (Word_Valid && Word_Ready)
                Word_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load_Valid) begin
                        Data_Out <= D;
                        cnt      <= '0;
                        rot      <= Rotate;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (Abort) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (Shift_En) begin
                        Data_Out <= shifted;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (slot_free) begin
                                Word_Data  <= shifted;
                                Word_Valid <= 1'b1;
                                Done       <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (Abort) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (Word_Ready) begin
                        Word_Data  <= Data_Out;
                        Word_Valid <= 1'b1;
                        Done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_serdes_var.sv
// Directed bench: LSB-first instance for the main scenarios, MSB-first
// instance for ordering and asynchronous reset.
module tb_shift_serdes_var;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load_Valid, Rotate, Shift_En, Shift_In, Abort, Word_Ready;
    logic [7:0] D;
    logic       Load_Ready, Shift_Out, Busy, Done, Word_Valid;
    logic [7:0] Data_Out, Word_Data;

    logic       m_Load_Valid, m_Rotate, m_Shift_En, m_Shift_In, m_Abort, m_Word_Ready;
    logic [7:0] m_D;
    logic       m_Load_Ready, m_Shift_Out, m_Busy, m_Done, m_Word_Valid;
    logic [7:0] m_Data_Out, m_Word_Data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    shift_serdes_var #(.WIDTH(8), .MSB_FIRST(0)) dut (
        .Clk(Clk), .Reset(Reset), .Load_Valid(Load_Valid), .Load_Ready(Load_Ready),
        .D(D), .Rotate(Rotate), .Shift_En(Shift_En), .Shift_In(Shift_In),
        .Abort(Abort), .Shift_Out(Shift_Out), .Data_Out(Data_Out), .Busy(Busy),
        .Done(Done), .Word_Valid(Word_Valid), .Word_Data(Word_Data),
        .Word_Ready(Word_Ready)
    );

    shift_serdes_var #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .Clk(Clk), .Reset(Reset), .Load_Valid(m_Load_Valid), .Load_Ready(m_Load_Ready),
        .D(m_D), .Rotate(m_Rotate), .Shift_En(m_Shift_En), .Shift_In(m_Shift_In),
        .Abort(m_Abort), .Shift_Out(m_Shift_Out), .Data_Out(m_Data_Out), .Busy(m_Busy),
        .Done(m_Done), .Word_Valid(m_Word_Valid), .Word_Data(m_Word_Data),
        .Word_Ready(m_Word_Ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic ld(input logic [7:0] d, input logic r);
        Load_Valid = 1'b1; D = d; Rotate = r;
        step();
        Load_Valid = 1'b0;
    endtask

    // so_exp[i] is the bit expected on Shift_Out before the i-th shift.
    task automatic sh(input int n, input logic [7:0] sin, input logic [7:0] so_exp, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, Shift_Out, so_exp[i]);
            Shift_In = sin[i]; Shift_En = 1'b1;
            step();
        end
        Shift_En = 1'b0;
    endtask

    task automatic m_sh(input int n, input logic [7:0] so_exp, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, m_Shift_Out, so_exp[i]);
            m_Shift_En = 1'b1;
            step();
        end
        m_Shift_En = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Load_Valid = 0; Rotate = 0; Shift_En = 0; Shift_In = 0; Abort = 0; Word_Ready = 1; D = '0;
        m_Load_Valid = 0; m_Rotate = 0; m_Shift_En = 0; m_Shift_In = 0; m_Abort = 0;
        m_Word_Ready = 0; m_D = '0;
        #2;
        chk("rst_data", Data_Out, 8'h00);
        chk("rst_ready", Load_Ready, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_wvalid", Word_Valid, 1'b0);
        chk("rst_sout", Shift_Out, 1'b0);
        step();
        Reset = 1'b0;
        step();

        // LSB-first: 0xA5 out, 0x3C in
        ld(8'hA5, 1'b0);
        chk("t1_busy", Busy, 1'b1);
        chk("t1_ready", Load_Ready, 1'b0);
        chk("t1_done_early", Done, 1'b0);
        sh(8, 8'h3C, 8'hA5, "t1_sout");   // expected 1,0,1,0,0,1,0,1
        chk("t1_done", Done, 1'b1);
        chk("t1_wdata", Word_Data, 8'h3C);
        chk("t1_wvalid", Word_Valid, 1'b1);
        chk("t1_ready_after", Load_Ready, 1'b1);
        step();
        chk("t1_done_pulse", Done, 1'b0);
        chk("t1_wvalid_clr", Word_Valid, 1'b0);

        // Rotate: Shift_In ignored
        ld(8'h81, 1'b1);
        sh(8, 8'hFF, 8'h81, "t2_sout");
        chk("t2_wdata", Word_Data, 8'h81);
        chk("t2_done", Done, 1'b1);

        // Sparse enables, one in three
        ld(8'h0F, 1'b0);
        Shift_In = 1'b0;
        for (int i = 0; i < 22; i++) begin
            Shift_En = (i % 3 == 0);
            step();
            if (i < 21) begin
                chk("t3_busy", Busy, 1'b1);
                chk("t3_done_early", Done, 1'b0);
            end
        end
        Shift_En = 1'b0;
        chk("t3_done", Done, 1'b1);
        chk("t3_wdata", Word_Data, 8'h00);
        step();

        // Backpressure: second word parks in DRAIN
        Word_Ready = 1'b0;
        ld(8'h11, 1'b1);
        sh(8, 8'h00, 8'h11, "t4_sout_a");
        chk("t4_wdata_a", Word_Data, 8'h11);
        chk("t4_wvalid_a", Word_Valid, 1'b1);
        ld(8'h22, 1'b1);
        sh(8, 8'h00, 8'h22, "t4_sout_b");
        chk("t4_drain_busy", Busy, 1'b1);
        chk("t4_drain_ready", Load_Ready, 1'b0);
        chk("t4_drain_done", Done, 1'b0);
        chk("t4_drain_wdata", Word_Data, 8'h11);
        chk("t4_drain_data", Data_Out, 8'h22);
        Shift_En = 1'b1; Shift_In = 1'b1; Rotate = 1'b0;
        step();
        Shift_En = 1'b0;
        chk("t4_drain_hold", Data_Out, 8'h22);
        chk("t4_drain_done2", Done, 1'b0);
        Word_Ready = 1'b1;
        step();
        Word_Ready = 1'b0;
        chk("t4_wdata_b", Word_Data, 8'h22);
        chk("t4_wvalid_b", Word_Valid, 1'b1);
        chk("t4_done_b", Done, 1'b1);
        chk("t4_idle", Load_Ready, 1'b1);

        // Abort after 3 shifts, coinciding with an enable
        ld(8'hF0, 1'b0);
        sh(3, 8'h00, 8'hF0, "t5_sout");
        Abort = 1'b1; Shift_En = 1'b1;
        step();
        Abort = 1'b0; Shift_En = 1'b0;
        chk("t5_data", Data_Out, 8'h1E);
        chk("t5_busy", Busy, 1'b0);
        chk("t5_ready", Load_Ready, 1'b1);
        chk("t5_done", Done, 1'b0);
        chk("t5_wvalid", Word_Valid, 1'b1);
        chk("t5_wdata", Word_Data, 8'h22);
        Word_Ready = 1'b1;
        step();
        chk("t5_wvalid_clr", Word_Valid, 1'b0);

        // Abort on the completing enable
        ld(8'h55, 1'b0);
        sh(7, 8'h00, 8'h55, "t5b_sout");
        Abort = 1'b1; Shift_En = 1'b1;
        step();
        Abort = 1'b0; Shift_En = 1'b0;
        chk("t5b_done", Done, 1'b0);
        chk("t5b_wvalid", Word_Valid, 1'b0);
        chk("t5b_busy", Busy, 1'b0);
        step();
        chk("t5b_done_late", Done, 1'b0);

        // MSB-first instance
        m_Load_Valid = 1'b1; m_D = 8'hC3; m_Rotate = 1'b0; m_Shift_In = 1'b1;
        step();
        m_Load_Valid = 1'b0;
        m_sh(8, 8'hC3, "t6_sout");          // expected 1,1,0,0,0,0,1,1
        chk("t6_wdata", m_Word_Data, 8'hFF);
        chk("t6_done", m_Done, 1'b1);
        m_Load_Valid = 1'b1;
        step();
        m_Load_Valid = 1'b0;
        m_sh(3, 8'hC3, "t6_sout2");
        chk("t6_data_mid", m_Data_Out, 8'h1F);
        #2;
        Reset = 1'b1;
        #1;
        chk("t6_rst_data", m_Data_Out, 8'h00);
        chk("t6_rst_sout", m_Shift_Out, 1'b0);
        chk("t6_rst_busy", m_Busy, 1'b0);
        chk("t6_rst_ready", m_Load_Ready, 1'b1);
        chk("t6_rst_wvalid", m_Word_Valid, 1'b0);
        chk("t6_rst_wdata", m_Word_Data, 8'h00);
        chk("t6_rst_done", m_Done, 1'b0);
        step();
        Reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
